elem_sram_reader: RTL and testbench

Drains the result SRAM (ELEM0 bank) to the AXI4-Stream master output after a GEMM/elementwise job. It sits directly downstream of the SRAM arbiter: it drives `read_sram_enable`/`read_idx`, which the arbiter uses to steer the ELEM0 bank address and read port, and consumes the bank's read data. Reads are issued against a 2-entry output buffer so `m00_axis_tready` backpressure never drops or duplicates a word. Throughput is one beat per cycle while `tready` is held high.

---
 rtl/npu_pkg.sv | 20 ++
 rtl/skid_fifo2.sv | 57 +++++
 rtl/elem_sram_reader.sv | 176 +++++++++++++++++
 tb/tb_elem_sram_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// npu_pkg
// Shared definitions for the NPU datapath blocks.
//   elem_rd_state_t    : state encoding of the result-SRAM reader FSM
//   MAX_ADDR_WIDTH     : default SRAM address width (also job base/length width)
//   MAX_DATA_WIDTH     : default SRAM read word width
//   C_AXIS_TDATA_WIDTH : default AXI4-Stream output width
package npu_pkg;

    localparam int MAX_ADDR_WIDTH     = 16;
    localparam int MAX_DATA_WIDTH     = 64;
    localparam int C_AXIS_TDATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } elem_rd_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2
// Two-entry FIFO used as the output buffer of the result-SRAM reader.
// Ports:
//   clk         : clock (rising edge)
//   arst        : asynchronous active-high reset
//   push_i      : write push_data_i this cycle
//   push_data_i : data to store
//   pop_i       : remove the head entry this cycle
//   occ_o       : number of stored entries (0..2)
//   head_data_o : head entry (meaningful while occ_o != 0)
// The writer guarantees it never pushes into a full FIFO and the reader
// never pops an empty one; push and pop together leave occ_o unchanged.
module skid_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [1:0]   occ_o,
    output logic [W-1:0] head_data_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   occ_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ_o       = occ_q;
    assign head_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/elem_sram_reader.sv
// elem_sram_reader
// Streams len words of the ELEM0 result SRAM, starting at base_addr, out of
// an AXI4-Stream master. Reads are credit-limited against a 2-entry output
// buffer so tready backpressure never drops or duplicates a word; with
// tready held high it sustains one beat per cycle.
// Ports:
//   clk, arst          : clock, asynchronous active-high reset
//   start              : one-cycle job request (honoured only when idle)
//   base_addr, len     : first SRAM word and word count, latched on start
//   busy, done         : job in progress / one-cycle end-of-job pulse
//   read_sram_enable   : read request to the arbiter / ELEM0 bank
//   read_idx           : read address (zero when no request)
//   sram_dout          : read data, valid one cycle after the request
//   m00_axis_*         : AXI4-Stream master (tdata/tvalid/tready/tlast)
//   stall_cnt          : cycles with tvalid & !tready while busy; present
//                        only when ELEM_READER_STALL_CNT_EN is defined
module elem_sram_reader #(
    parameter int MAX_ADDR_WIDTH     = npu_pkg::MAX_ADDR_WIDTH,
    parameter int MAX_DATA_WIDTH     = npu_pkg::MAX_DATA_WIDTH,
    parameter int C_AXIS_TDATA_WIDTH = npu_pkg::C_AXIS_TDATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          start,
    input  logic [MAX_ADDR_WIDTH-1:0]     base_addr,
    input  logic [MAX_ADDR_WIDTH-1:0]     len,
    output logic                          busy,
    output logic                          done,
    output logic                          read_sram_enable,
    output logic [MAX_ADDR_WIDTH-1:0]     read_idx,
    input  logic [MAX_DATA_WIDTH-1:0]     sram_dout,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                          m00_axis_tvalid,
    output logic                          m00_axis_tlast,
    input  logic                          m00_axis_tready
`ifdef ELEM_READER_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt
`endif
);

    import npu_pkg::*;

    localparam logic [MAX_ADDR_WIDTH-1:0] ONE = MAX_ADDR_WIDTH'(1);

    elem_rd_state_t                state_q;
    logic [MAX_ADDR_WIDTH-1:0]     base_q;
    logic [MAX_ADDR_WIDTH-1:0]     len_q;
    logic [MAX_ADDR_WIDTH-1:0]     issue_cnt_q;
    logic [MAX_ADDR_WIDTH-1:0]     beat_cnt_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          inflight_q;

    logic [1:0]                    occ;
    logic [C_AXIS_TDATA_WIDTH-1:0] head_data;
    logic                          pop;
    logic                          rd_en;
    logic [2:0]                    credit_used;
    logic                          last_issue;
    logic                          last_beat;

    // Words already committed to the buffer: stored + returning next cycle,
    // minus the one leaving now. A new read needs a free slot among the two.
    assign m00_axis_tvalid = (occ != 2'd0);
    assign pop             = m00_axis_tvalid & m00_axis_tready;
    assign credit_used     = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en           = (state_q == READ) && (credit_used < 3'd2);

    assign read_sram_enable = rd_en;
    assign read_idx         = rd_en ? (base_q + issue_cnt_q) : '0;

    assign last_issue = (issue_cnt_q == len_q - ONE);
    assign last_beat  = (beat_cnt_q == len_q - ONE);

    assign m00_axis_tlast = m00_axis_tvalid & last_beat;
    assign m00_axis_tdata = m00_axis_tvalid ? head_data : '0;
    assign busy           = busy_q;
    assign done           = done_q;

    skid_fifo2 #(
        .W (C_AXIS_TDATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .arst        (arst),
        .push_i      (inflight_q),
        .push_data_i (sram_dout[C_AXIS_TDATA_WIDTH-1:0]),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_data_o (head_data)
    );

    // Only the low stream-width bits of the SRAM word are forwarded.
    generate
        if (MAX_DATA_WIDTH > C_AXIS_TDATA_WIDTH) begin : g_dout_hi
            logic unused_dout_hi;
            assign unused_dout_hi = ^sram_dout[MAX_DATA_WIDTH-1:C_AXIS_TDATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            if (pop) begin
                beat_cnt_q <= beat_cnt_q + ONE;
            end
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (len != '0) begin
                            base_q      <= base_addr;
                            len_q       <= len;
                            issue_cnt_q <= '0;
                            beat_cnt_q  <= '0;
                            state_q     <= READ;
                        end else begin
                            // Empty job: report completion straight away.
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                READ: begin
                    if (rd_en) begin
                        issue_cnt_q <= issue_cnt_q + ONE;
                        if (last_issue) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && last_beat) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ELEM_READER_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            stall_q <= '0;
        end else if (busy_q && m00_axis_tvalid && !m00_axis_tready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_elem_sram_reader.sv
// tb_elem_sram_reader
// Drives jobs into elem_sram_reader with fixed and $urandom-driven tready
// patterns, models the SRAM as addr+0x100 and scores every beat against the
// list of words the job should produce. Build with ELEM_READER_STALL_CNT_EN
// defined to also check the stall counter.
module tb_elem_sram_reader;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        read_sram_enable;
    logic [15:0] read_idx;
    logic [63:0] sram_dout = '0;
    logic [31:0] m00_axis_tdata;
    logic        m00_axis_tvalid;
    logic        m00_axis_tlast;
    logic        m00_axis_tready;
`ifdef ELEM_READER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    elem_sram_reader dut (
        .clk              (clk),
        .arst             (arst),
        .start            (start),
        .base_addr        (base_addr),
        .len              (len),
        .busy             (busy),
        .done             (done),
        .read_sram_enable (read_sram_enable),
        .read_idx         (read_idx),
        .sram_dout        (sram_dout),
        .m00_axis_tdata   (m00_axis_tdata),
        .m00_axis_tvalid  (m00_axis_tvalid),
        .m00_axis_tlast   (m00_axis_tlast),
        .m00_axis_tready  (m00_axis_tready)
`ifdef ELEM_READER_STALL_CNT_EN
        ,
        .stall_cnt        (stall_cnt)
`endif
    );

    // SRAM: one-cycle read latency, word = address + 0x100 with junk above.
    always @(posedge clk) begin
        if (read_sram_enable) begin
            sram_dout <= {32'hDEAD_BEEF, 32'(read_idx) + 32'h100};
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [15:0] b, input int i);
        logic [15:0] a;
        a = b + 16'(i);
        return 32'(a) + 32'h100;
    endfunction

    // mode 0: ready always; 1: ready 1,0,0,1 repeating; 2: random ready plus a
    // stray start mid-job; 3: ready low for cycles 3..7 (first valid is cycle 3)
    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            1:       return ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
            2:       return ($urandom_range(0, 2) != 0);
            3:       return !(cyc >= 3 && cyc <= 7);
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_job(input logic [15:0] b, input logic [15:0] n, input int mode, input int abort_at);
        int          issued;
        int          beats;
        int          cyc;
        int          last_hs;
        int          first_rd;
        int          first_v;
        int          stalls;
        bit          finished;
        bit          aborted;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [15:0] ea;
        issued = 0; beats = 0; cyc = 0; last_hs = -1; first_rd = -1; first_v = -1;
        stalls = 0; finished = 0; aborted = 0; prev_stall = 0; prev_data = '0; prev_last = 0;

        @(negedge clk);
        start = 1'b1; base_addr = b; len = n; m00_axis_tready = 1'b1;
        #1;
        chk("idle_busy", 64'(busy), 64'd0);

        while (!finished && !aborted && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (mode == 2 && cyc == 4);
            if (start) begin
                base_addr = 16'($urandom);
                len       = 16'($urandom_range(1, 9));
            end
            m00_axis_tready = ready_for(mode, cyc);
            #1;
            chk("busy", 64'(busy), 64'd1);
            if (read_sram_enable) begin
                ea = b + 16'(issued);
                chk("read_idx", 64'(read_idx), 64'(ea));
                if (first_rd < 0) first_rd = cyc;
                issued++;
            end
            if (m00_axis_tvalid && first_v < 0) first_v = cyc;
            if (prev_stall) begin
                chk("hold_valid", 64'(m00_axis_tvalid), 64'd1);
                chk("hold_data", 64'(m00_axis_tdata), 64'(prev_data));
                chk("hold_last", 64'(m00_axis_tlast), 64'(prev_last));
            end
            if (m00_axis_tvalid && m00_axis_tready) begin
                chk("tdata", 64'(m00_axis_tdata), 64'(exp_word(b, beats)));
                chk("tlast", 64'(m00_axis_tlast), 64'(beats == int'(n) - 1));
                beats++;
                last_hs = cyc;
            end else if (m00_axis_tvalid) begin
                stalls++;
            end
            prev_stall = m00_axis_tvalid && !m00_axis_tready;
            prev_data  = m00_axis_tdata;
            prev_last  = m00_axis_tlast;
            chk("held_le2", 64'((issued - beats) <= 2), 64'd1);
            chk("rd_cap", 64'(issued <= int'(n)), 64'd1);

            if (done) begin
                finished = 1;
                chk("done_tvalid", 64'(m00_axis_tvalid), 64'd0);
                chk("done_rden", 64'(read_sram_enable), 64'd0);
                chk("beats", 64'(beats), 64'(n));
                chk("issued", 64'(issued), 64'(n));
                if (n == 16'd0) begin
                    chk("done_t1", 64'(cyc), 64'd1);
                end else begin
                    chk("done_lat", 64'(cyc), 64'(last_hs + 1));
                end
                if (mode == 0 && n != 16'd0) begin
                    chk("first_rd", 64'(first_rd), 64'd1);
                    chk("first_valid", 64'(first_v), 64'd3);
                    chk("last_hs", 64'(last_hs), 64'(int'(n) + 2));
                end
`ifdef ELEM_READER_STALL_CNT_EN
                chk("stall_cnt", 64'(stall_cnt), 64'(stalls));
                if (mode == 3) chk("stall_cnt5", 64'(stall_cnt), 64'd5);
`endif
            end else if (abort_at >= 0 && beats == abort_at) begin
                aborted = 1;
                arst = 1'b1;
                #1;
                chk("rst_zero", {busy, done, read_sram_enable, m00_axis_tvalid, m00_axis_tlast,
                                 read_idx, m00_axis_tdata}, 64'd0);
                @(negedge clk);
                #1;
                chk("rst_hold", {busy, done, read_sram_enable, m00_axis_tvalid}, 64'd0);
                arst = 1'b0;
            end
        end

        start = 1'b0;
        if (!finished && !aborted) chk("timeout", 64'd0, 64'd1);
        if (!aborted) begin
            @(negedge clk);
            #1;
            chk("post_busy", 64'(busy), 64'd0);
            chk("post_done", 64'(done), 64'd0);
            chk("idle_idx", 64'(read_idx), 64'd0);
        end
        $display("job base=0x%04h len=%0d mode=%0d beats=%0d cycles=%0d stalls=%0d %s",
                 b, n, mode, beats, cyc, stalls, aborted ? "reset-aborted" : "complete");
    endtask

    initial begin
        arst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m00_axis_tready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out", {busy, done, read_sram_enable, m00_axis_tvalid, m00_axis_tlast,
                          read_idx, m00_axis_tdata}, 64'd0);
`ifdef ELEM_READER_STALL_CNT_EN
        chk("reset_stall", 64'(stall_cnt), 64'd0);
`endif
        arst = 1'b0;

        run_job(16'h0010, 16'd4, 0, -1);
        run_job(16'h0020, 16'd8, 1, -1);
        run_job(16'hFFFE, 16'd4, 0, -1);
        run_job(16'h0000, 16'd0, 0, -1);
        run_job(16'h0100, 16'd6, 0, 3);
        run_job(16'h0200, 16'd2, 0, -1);
        run_job(16'h0300, 16'd4, 3, -1);
        for (int k = 0; k < 6; k++) begin
            run_job(16'($urandom), 16'($urandom_range(1, 12)), 2, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
